// File: rtl/divider_seq_if.sv
// divider_seq handshake/data bundle.
// slave: start/dividend/divisor in; quotient/remainder/busy/done/divByZero out.
interface divider_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;
  logic             done;
  logic             divByZero;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder,
    input  busy, done, divByZero
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder,
    output busy, done, divByZero
  );
endinterface

// File: rtl/divider_seq.sv
// Sequential restoring unsigned divider, one quotient bit per clock.
// Ports: clk, rst (async high), io (slave): start/operands in, results/status out.
module divider_seq #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  divider_seq_if.slave  io
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH:0]   p_q, p_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   t;
  logic             ge;
  logic [WIDTH:0]   step_p;
  logic [WIDTH-1:0] step_q;

  // One restoring step: shift next dividend bit into P,
  // subtract D when it fits.
  always_comb begin
    t      = {p_q[WIDTH-1:0], q_q[WIDTH-1]};
    ge     = (t >= {1'b0, d_q});
    step_p = ge ? (t - {1'b0, d_q}) : t;
    step_q = {q_q[WIDTH-2:0], ge};
  end

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    d_d     = d_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (io.start) begin
          q_d     = io.dividend;
          d_d     = io.divisor;
          p_d     = '0;
          cnt_d   = CW'(WIDTH - 1);
          state_d = RUN;
        end
      end
      RUN: begin
        p_d   = step_p;
        q_d   = step_q;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          // Publish straight from the final step's result.
          quo_d   = step_q;
          rem_d   = step_p[WIDTH-1:0];
          dbz_d   = (d_q == '0);
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      q_q     <= '0;
      d_q     <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      d_q     <= d_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  // Status decodes straight off the state register.
  assign io.busy      = (state_q == RUN);
  assign io.done      = (state_q == DONE);
  assign io.quotient  = quo_q;
  assign io.remainder = rem_q;
  assign io.divByZero = dbz_q;
endmodule

// File: tb/tb_divider_seq.sv
// Directed scoreboard bench for divider_seq (WIDTH=32).
// Expected results are queued at drive time and popped on done.
module tb_divider_seq;
  localparam int W = 32;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  exp_t sb[$];
  logic [W-1:0] last_q;

  divider_seq_if #(.WIDTH(W)) io ();

  divider_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    exp_t e;
    if (b == '0) begin
      e.q = '1;
      e.r = a;
      e.z = 1'b1;
    end else begin
      e.q = a / b;
      e.r = a % b;
      e.z = 1'b0;
    end
    return e;
  endfunction

  task automatic pop_chk(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_quo"}, 64'(io.quotient), 64'(e.q));
      chk({tag, "_rem"}, 64'(io.remainder), 64'(e.r));
      chk({tag, "_dbz"}, 64'(io.divByZero), 64'(e.z));
      last_q = e.q;
    end
  endtask

  // Drive one division; measure latency and busy time.
  task automatic do_div(input string tag,
                        input logic [W-1:0] a,
                        input logic [W-1:0] b);
    int n;
    int nb;
    bit seen;
    sb.push_back(model(a, b));
    io.start    = 1'b1;
    io.dividend = a;
    io.divisor  = b;
    @(posedge clk);
    #1;
    io.start    = 1'b0;
    io.dividend = $urandom;
    io.divisor  = $urandom;
    n  = 0;
    nb = 0;
    seen = 0;
    while (!seen && n < 100) begin
      @(negedge clk);
      n++;
      if (n == 10)
        chk({tag, "_hold"}, 64'(io.quotient), 64'(last_q));
      if (io.busy) nb++;
      if (io.done) seen = 1;
    end
    chk({tag, "_lat"}, 64'(n), 64'd33);
    chk({tag, "_busy"}, 64'(nb), 64'd32);
    if (seen) pop_chk(tag);
    @(negedge clk);
    chk({tag, "_pulse"}, 64'(io.done), 64'd0);
    #1;
  endtask

  initial begin
    int n;
    int dn;
    int d1;
    int d2;
    checks   = 0;
    failures = 0;
    last_q   = '0;
    io.start    = 1'b0;
    io.dividend = '0;
    io.divisor  = '0;
    rst = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    chk("rst_quo", 64'(io.quotient), 64'd0);
    chk("rst_rem", 64'(io.remainder), 64'd0);
    chk("rst_busy", 64'(io.busy), 64'd0);
    chk("rst_done", 64'(io.done), 64'd0);
    chk("rst_dbz", 64'(io.divByZero), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    do_div("d100_7", 32'd100, 32'd7);
    do_div("max_1", 32'hFFFF_FFFF, 32'd1);
    do_div("max_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_div("dz", 32'h1234_5678, 32'd0);
    do_div("small", 32'd5, 32'd9);
    do_div("zero", 32'd0, 32'd13);
    do_div("rnd1", $urandom, 32'd1 + 32'($urandom_range(0, 65535)));
    do_div("rnd2", $urandom, $urandom | 32'h8000_0000);

    // Abandon a run with an async reset.
    io.start    = 1'b1;
    io.dividend = 32'd1000;
    io.divisor  = 32'd3;
    @(posedge clk);
    #1;
    io.start = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid_busy", 64'(io.busy), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_quo", 64'(io.quotient), 64'd0);
    chk("mid_rem", 64'(io.remainder), 64'd0);
    chk("mid_busy0", 64'(io.busy), 64'd0);
    chk("mid_dbz", 64'(io.divByZero), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    dn = 0;
    repeat (40) begin
      @(negedge clk);
      if (io.done) dn++;
    end
    chk("mid_nodone", 64'(dn), 64'd0);
    #1;
    last_q = '0;
    do_div("d50_5", 32'd50, 32'd5);

    // Held start: operands change during RUN.
    sb.push_back(model(32'd100, 32'd7));
    sb.push_back(model(32'd200, 32'd3));
    io.start    = 1'b1;
    io.dividend = 32'd100;
    io.divisor  = 32'd7;
    @(posedge clk);
    #1;
    io.dividend = 32'd200;
    io.divisor  = 32'd3;
    n  = 0;
    dn = 0;
    d1 = 0;
    d2 = 0;
    while (n < 90) begin
      @(negedge clk);
      n++;
      if (n == 35) io.start = 1'b0;
      if (io.done) begin
        dn++;
        if (dn == 1) d1 = n;
        if (dn == 2) d2 = n;
        pop_chk($sformatf("held%0d", dn));
      end
    end
    chk("held_cnt", 64'(dn), 64'd2);
    chk("held_d1", 64'(d1), 64'd33);
    chk("held_d2", 64'(d2), 64'd67);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
